// File: rtl/pc_pkg.sv
// Shared types for the program-counter sequencer: FSM states, next-PC select
// codes and the alignment-mask helper used for misaligned-redirect detection.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        SEL_TRAP  = 3'd0,
        SEL_REDIR = 3'd1,
        SEL_RAS   = 3'd2,
        SEL_HOLD  = 3'd3,
        SEL_INC   = 3'd4
    } sel_t;

    // Low-order address bits that must be zero for a target aligned to inc bytes.
    function automatic logic [63:0] align_mask(input int unsigned inc);
        return 64'(inc) - 64'd1;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack with saturating occupancy count; a full push
// overwrites the oldest entry. Used by pc_sequencer only when PC_RAS_EN is defined.
module pc_ras
    import pc_pkg::*;
#(
    parameter int          XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic            i_clear,
    input  logic [XLEN-1:0] i_push_data,
    output logic [XLEN-1:0] o_top,
    output logic            o_empty,
    output logic            o_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [XLEN-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [PTR_W-1:0] w_top_idx;
    logic             w_pop_ok;

    // r_ptr is the next free slot; the top of stack sits just below it.
    assign w_top_idx = r_ptr - PTR_W'(1);
    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == FULL_CNT);
    assign o_top     = r_mem[w_top_idx];
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (i_push && w_pop_ok) begin
            r_ptr <= r_ptr;
            r_cnt <= r_cnt;
        end else if (i_push) begin
            r_ptr <= r_ptr + PTR_W'(1);
            if (!o_full) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (w_pop_ok) begin
            r_ptr <= w_top_idx;
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Entry storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (!i_clear) begin
            if (i_push && w_pop_ok) begin
                r_mem[w_top_idx] <= i_push_data;
            end else if (i_push) begin
                r_mem[r_ptr] <= i_push_data;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with trap/redirect/stall/halt control and misaligned-target trapping.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int unsigned     INC          = 4,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_target_i,
    input  logic            trap_i,
    input  logic            halt_i,
    input  logic            resume_i,
    input  logic            call_i,
    input  logic            ret_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_next_o,
    output logic            pc_valid_o,
    output logic            misalign_o,
    output logic            ras_underflow_o
);

    localparam logic [63:0]     MASK64     = align_mask(INC);
    localparam logic [XLEN-1:0] ALIGN_MASK = MASK64[XLEN-1:0];
    localparam logic [XLEN-1:0] INC_X      = XLEN'(INC);

    state_t          r_state;
    state_t          w_state_d;
    sel_t            w_sel;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_pc_inc;
    logic            r_valid;
    logic            r_misalign;
    logic            r_underflow;
    logic            w_misaligned;
    logic            w_in_run;
    logic            w_pop;
    logic            w_ret_empty;
    logic [XLEN-1:0] w_ras_top;

    assign w_pc_inc     = r_pc + INC_X;
    assign w_misaligned = |(redirect_target_i & ALIGN_MASK);
    assign w_in_run     = (r_state == RUN);

`ifdef PC_RAS_EN
    logic w_push;
    logic w_clear;
    logic w_ras_empty;
    logic w_unused_ras_full;

    // A return only consumes the stack when nothing of higher priority redirects.
    assign w_push      = w_in_run && call_i && !trap_i;
    assign w_clear     = (r_state != BOOT) && trap_i;
    assign w_pop       = w_in_run && ret_i && !trap_i && !redirect_i && !w_ras_empty;
    assign w_ret_empty = w_in_run && ret_i && !trap_i && !redirect_i && w_ras_empty;

    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_clear     (w_clear),
        .i_push_data (w_pc_inc),
        .o_top       (w_ras_top),
        .o_empty     (w_ras_empty),
        .o_full      (w_unused_ras_full)
    );
`else
    localparam int unsigned RAS_DEPTH_UNUSED = RAS_DEPTH;
    logic w_unused_ras;

    assign w_unused_ras = call_i | ret_i;
    assign w_pop        = 1'b0;
    assign w_ret_empty  = 1'b0;
    assign w_ras_top    = '0;
`endif

    always_comb begin
        w_sel     = SEL_HOLD;
        w_state_d = r_state;
        case (r_state)
            BOOT: w_state_d = RUN;
            RUN: begin
                if (trap_i) begin
                    w_sel = SEL_TRAP;
                end else if (redirect_i) begin
                    w_sel = w_misaligned ? SEL_TRAP : SEL_REDIR;
                end else if (w_pop) begin
                    w_sel = SEL_RAS;
                end else if (halt_i) begin
                    w_state_d = HALT;
                end else if (!stall_i) begin
                    w_sel = SEL_INC;
                end
            end
            HALT: begin
                if (trap_i) begin
                    w_sel     = SEL_TRAP;
                    w_state_d = RUN;
                end else if (resume_i) begin
                    w_state_d = RUN;
                end
            end
            default: w_state_d = BOOT;
        endcase
    end

    always_comb begin
        w_pc_next = r_pc;
        case (w_sel)
            SEL_TRAP:  w_pc_next = TRAP_VECTOR;
            SEL_REDIR: w_pc_next = redirect_target_i;
            SEL_RAS:   w_pc_next = w_ras_top;
            SEL_INC:   w_pc_next = w_pc_inc;
            default:   w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= BOOT;
            r_pc        <= RESET_VECTOR;
            r_valid     <= 1'b0;
            r_misalign  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_pc        <= w_pc_next;
            r_valid     <= (w_state_d == RUN);
            r_misalign  <= w_in_run && !trap_i && redirect_i && w_misaligned;
            r_underflow <= w_ret_empty;
        end
    end

    assign pc_o            = r_pc;
    assign pc_next_o       = w_pc_next;
    assign pc_valid_o      = r_valid;
    assign misalign_o      = r_misalign;
    assign ras_underflow_o = r_underflow;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer; a 32-bit and a 16-bit instance share stimulus.
module tb_pc_sequencer;

    localparam logic [6:0] S  = 7'h01;  // stall
    localparam logic [6:0] R  = 7'h02;  // redirect
    localparam logic [6:0] T  = 7'h04;  // trap
    localparam logic [6:0] H  = 7'h08;  // halt
    localparam logic [6:0] U  = 7'h10;  // resume
    localparam logic [6:0] C  = 7'h20;  // call
    localparam logic [6:0] RT = 7'h40;  // ret
    localparam logic [2:0] V  = 3'b100; // expect pc_valid_o
    localparam logic [2:0] M  = 3'b010; // expect misalign_o
    localparam logic [2:0] UF = 3'b001; // expect ras_underflow_o

    typedef struct {
        logic [6:0]  ctl;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic [15:0] pc16;
        logic [2:0]  f;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic        stall_i, redirect_i, trap_i, halt_i, resume_i, call_i, ret_i;
    logic [31:0] redirect_target_i;
    logic [31:0] pc_o, pc_next_o;
    logic        pc_valid_o, misalign_o, ras_underflow_o;
    logic [15:0] pc16_o, pc_next16_o;
    logic        pc_valid16_o, misalign16_o, ras_underflow16_o;

    int n_pass;
    int n_total;

    pc_sequencer dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .stall_i           (stall_i),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .trap_i            (trap_i),
        .halt_i            (halt_i),
        .resume_i          (resume_i),
        .call_i            (call_i),
        .ret_i             (ret_i),
        .pc_o              (pc_o),
        .pc_next_o         (pc_next_o),
        .pc_valid_o        (pc_valid_o),
        .misalign_o        (misalign_o),
        .ras_underflow_o   (ras_underflow_o)
    );

    pc_sequencer #(.XLEN(16)) dut16 (
        .clk               (clk),
        .reset_n           (reset_n),
        .stall_i           (stall_i),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i[15:0]),
        .trap_i            (trap_i),
        .halt_i            (halt_i),
        .resume_i          (resume_i),
        .call_i            (call_i),
        .ret_i             (ret_i),
        .pc_o              (pc16_o),
        .pc_next_o         (pc_next16_o),
        .pc_valid_o        (pc_valid16_o),
        .misalign_o        (misalign16_o),
        .ras_underflow_o   (ras_underflow16_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [6:0] ctl, input logic [31:0] tgt,
                                input logic [31:0] pc, input logic [15:0] pc16,
                                input logic [2:0] f);
        vec_t v;
        v.ctl = ctl; v.tgt = tgt; v.pc = pc; v.pc16 = pc16; v.f = f;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check the combinational
    // next PC, then check registered outputs just after the rising edge.
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        stall_i           = v.ctl[0];
        redirect_i        = v.ctl[1];
        trap_i            = v.ctl[2];
        halt_i            = v.ctl[3];
        resume_i          = v.ctl[4];
        call_i            = v.ctl[5];
        ret_i             = v.ctl[6];
        redirect_target_i = v.tgt;
        #1;
        chk({tag, " pc_next"},   64'(pc_next_o),   64'(v.pc));
        chk({tag, " pc_next16"}, 64'(pc_next16_o), 64'(v.pc16));
        @(posedge clk);
        #1;
        chk({tag, " pc"},        64'(pc_o),            64'(v.pc));
        chk({tag, " pc16"},      64'(pc16_o),          64'(v.pc16));
        chk({tag, " valid"},     64'(pc_valid_o),      64'(v.f[2]));
        chk({tag, " valid16"},   64'(pc_valid16_o),    64'(v.f[2]));
        chk({tag, " misalign"},  64'(misalign_o),      64'(v.f[1]));
        chk({tag, " misalign16"},64'(misalign16_o),    64'(v.f[1]));
        chk({tag, " underflow"}, 64'(ras_underflow_o), 64'(v.f[0]));
        chk({tag, " underflow16"},64'(ras_underflow16_o),64'(v.f[0]));
    endtask

    vec_t tbl[25];
    vec_t ras[15];

    initial begin
        n_pass = 0;
        n_total = 0;
        reset_n = 1'b0;
        {stall_i, redirect_i, trap_i, halt_i, resume_i, call_i, ret_i} = '0;
        redirect_target_i = '0;

        tbl[0]  = mk(0,     32'h0,      32'h0,     16'h0,    V);
        tbl[1]  = mk(0,     32'h0,      32'h4,     16'h4,    V);
        tbl[2]  = mk(0,     32'h0,      32'h8,     16'h8,    V);
        tbl[3]  = mk(S,     32'h0,      32'h8,     16'h8,    V);
        tbl[4]  = mk(S,     32'h0,      32'h8,     16'h8,    V);
        tbl[5]  = mk(0,     32'h0,      32'hC,     16'hC,    V);
        tbl[6]  = mk(S|R,   32'h40,     32'h40,    16'h40,   V);
        tbl[7]  = mk(R,     32'h42,     32'h100,   16'h100,  V|M);
        tbl[8]  = mk(0,     32'h0,      32'h104,   16'h104,  V);
        tbl[9]  = mk(R|T,   32'h42,     32'h100,   16'h100,  V);
        tbl[10] = mk(R,     32'h20,     32'h20,    16'h20,   V);
        tbl[11] = mk(H,     32'h0,      32'h20,    16'h20,   0);
        tbl[12] = mk(0,     32'h0,      32'h20,    16'h20,   0);
        tbl[13] = mk(0,     32'h0,      32'h20,    16'h20,   0);
        tbl[14] = mk(0,     32'h0,      32'h20,    16'h20,   0);
        tbl[15] = mk(0,     32'h0,      32'h20,    16'h20,   0);
        tbl[16] = mk(S|R,   32'h80,     32'h20,    16'h20,   0);
        tbl[17] = mk(U,     32'h0,      32'h20,    16'h20,   V);
        tbl[18] = mk(0,     32'h0,      32'h24,    16'h24,   V);
        tbl[19] = mk(H|U,   32'h0,      32'h24,    16'h24,   0);
        tbl[20] = mk(T|U,   32'h0,      32'h100,   16'h100,  V);
        tbl[21] = mk(0,     32'h0,      32'h104,   16'h104,  V);
        tbl[22] = mk(R,     32'hFFFC,   32'hFFFC,  16'hFFFC, V);
        tbl[23] = mk(0,     32'h0,      32'h10000, 16'h0000, V);
        tbl[24] = mk(0,     32'h0,      32'h10004, 16'h0004, V);

        ras[0]  = mk(R,     32'h10,     32'h10,    16'h10,   V);
        ras[1]  = mk(C|R,   32'h20,     32'h20,    16'h20,   V);
        ras[2]  = mk(C|R,   32'h30,     32'h30,    16'h30,   V);
        ras[3]  = mk(C|R,   32'h40,     32'h40,    16'h40,   V);
        ras[4]  = mk(C|R,   32'h50,     32'h50,    16'h50,   V);
        ras[5]  = mk(C|R,   32'h60,     32'h60,    16'h60,   V);
`ifdef PC_RAS_EN
        ras[6]  = mk(RT,    32'h0,      32'h54,    16'h54,   V);
        ras[7]  = mk(RT,    32'h0,      32'h44,    16'h44,   V);
        ras[8]  = mk(RT,    32'h0,      32'h34,    16'h34,   V);
        ras[9]  = mk(RT,    32'h0,      32'h24,    16'h24,   V);
        ras[10] = mk(RT,    32'h0,      32'h28,    16'h28,   V|UF);
        ras[11] = mk(0,     32'h0,      32'h2C,    16'h2C,   V);
        ras[14] = mk(RT,    32'h0,      32'h104,   16'h104,  V|UF);
`else
        ras[6]  = mk(RT,    32'h0,      32'h64,    16'h64,   V);
        ras[7]  = mk(RT,    32'h0,      32'h68,    16'h68,   V);
        ras[8]  = mk(RT,    32'h0,      32'h6C,    16'h6C,   V);
        ras[9]  = mk(RT,    32'h0,      32'h70,    16'h70,   V);
        ras[10] = mk(RT,    32'h0,      32'h74,    16'h74,   V);
        ras[11] = mk(0,     32'h0,      32'h78,    16'h78,   V);
        ras[14] = mk(RT,    32'h0,      32'h104,   16'h104,  V);
`endif
        ras[12] = mk(C|R,   32'h80,     32'h80,    16'h80,   V);
        ras[13] = mk(C|T,   32'h0,      32'h100,   16'h100,  V);

        repeat (2) @(posedge clk);
        #1;
        chk("reset pc",        64'(pc_o),            64'h0);
        chk("reset pc16",      64'(pc16_o),          64'h0);
        chk("reset valid",     64'(pc_valid_o),      64'h0);
        chk("reset misalign",  64'(misalign_o),      64'h0);
        chk("reset underflow", 64'(ras_underflow_o), 64'h0);

        @(posedge clk);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            run_vec(tbl[i], $sformatf("v%0d", i));
        end

        // Asynchronous reset asserted between edges at pc_o = 0x30.
        run_vec(mk(R, 32'h30, 32'h30, 16'h30, V), "pre-reset");
        #1 reset_n = 1'b0;
        #1;
        chk("async reset pc",    64'(pc_o),       64'h0);
        chk("async reset pc16",  64'(pc16_o),     64'h0);
        chk("async reset valid", 64'(pc_valid_o), 64'h0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        run_vec(mk(0, 32'h0, 32'h0, 16'h0, V), "reboot");

        for (int i = 0; i < 15; i++) begin
            run_vec(ras[i], $sformatf("ras%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised next-generation program counter for the single-cycle/pipelined datapath. Holds the fetch byte address and selects the next PC from sequential increment, branch/jump redirect, or trap vector. Supports stall, halt/resume and misaligned-target detection. Sits between the control/branch unit and instruction memory, replacing the fixed increment-by-4 counter.

Parameters:
XLEN, 32, PC width in bits (16..64)
RESET_VECTOR, 0, PC value loaded on reset
TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap or misaligned redirect
INC, 4, sequential increment in bytes (power of two)
RAS_DEPTH, 4, return-address-stack entries (used only with PC_RAS_EN; power of two, >=2)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  reset, asynchronous, active-low
stall_i  in  1  hold PC this cycle
redirect_i  in  1  taken branch/jump this cycle
redirect_target_i  in  XLEN  redirect byte address
trap_i  in  1  exception/interrupt; jump to TRAP_VECTOR
halt_i  in  1  request halt
resume_i  in  1  leave HALT
call_i  in  1  push pc_o+INC on RAS (PC_RAS_EN only; ignored otherwise)
ret_i  in  1  pop RAS and redirect (PC_RAS_EN only; ignored otherwise)
pc_o  out  XLEN  current fetch address (registered)
pc_next_o  out  XLEN  value pc_o takes at next edge (combinational)
pc_valid_o  out  1  pc_o is a valid fetch address (registered)
misalign_o  out  1  one-cycle pulse: last redirect target misaligned (registered)
ras_underflow_o  out  1  one-cycle pulse: ret_i with empty RAS (registered; tied 0 without PC_RAS_EN)

Behaviour:
- Reset (async assert, sync release): pc_o=RESET_VECTOR, pc_valid_o=0, misalign_o=0, ras_underflow_o=0, state=BOOT, RAS emptied.
- States: BOOT, RUN, HALT.
- BOOT: first edge after release -> RUN, pc_valid_o=1, pc_o unchanged (RESET_VECTOR fetched first). All inputs ignored in BOOT.
- RUN next-PC priority, highest first: trap_i -> TRAP_VECTOR; redirect_i -> redirect_target_i; ret_i (RAS) -> popped address; halt_i -> enter HALT, pc_o held; stall_i -> hold; else pc_o+INC.
- trap_i, redirect_i and ret_i override stall_i (flush semantics); stall never blocks a redirect.
- Misaligned: if redirect_i and redirect_target_i[log2(INC)-1:0]!=0 -> pc_o=TRAP_VECTOR, misalign_o=1 for one cycle. Trap_i simultaneous -> plain trap, misalign_o=0.
- HALT: pc_valid_o=0, pc_o held. resume_i -> RUN next edge, pc_valid_o=1, pc_o unchanged. trap_i in HALT -> RUN with pc_o=TRAP_VECTOR (trap wins over resume). redirect_i/stall_i ignored in HALT.
- halt_i and resume_i together in RUN: halt wins.
- Arithmetic modulo 2^XLEN: pc_o=2^XLEN-INC increments to 0, no flag.
- Latency: every redirect visible on pc_o one edge after its input cycle; pc_next_o shows it same cycle.

Optional Feature:
Macro PC_RAS_EN. Defined: RAS_DEPTH-entry circular return-address stack with count register. call_i (RUN, no trap) pushes pc_o+INC; full -> overwrite oldest, count saturates at RAS_DEPTH. ret_i pops top and redirects; empty -> no redirect, sequential increment, ras_underflow_o pulses. call_i+ret_i same cycle: pop then push (top replaced, count unchanged). trap_i clears RAS. Not defined: no RAS storage, call_i/ret_i ignored, ras_underflow_o tied 0.

Decomposition:
- Package pc_pkg: state enum (BOOT, RUN, HALT), next-PC select encoding (SEL_TRAP, SEL_REDIR, SEL_RAS, SEL_HOLD, SEL_INC), alignment-mask function.
- One sub-module: pc_ras (stack storage, pointer, count, push/pop, full/empty), instantiated only under PC_RAS_EN.

Test Plan:
- Reset release, no stimulus -> pc_o 0 (valid 0), 0 (valid 1), 4, 8, 12 on consecutive edges.
- At pc_o=8 assert stall_i 2 cycles -> pc_o 8,8,8 then 12; stall_i+redirect_i to 0x40 -> pc_o=0x40 next edge.
- redirect_i to 0x42 -> pc_o=0x100, misalign_o=1 one cycle; same cycle with trap_i -> pc_o=0x100, misalign_o=0.
- halt_i at pc_o=0x20 -> pc_valid_o=0, pc_o 0x20 held 5 cycles; resume_i -> pc_valid_o=1, pc_o 0x20 then 0x24; trap_i during HALT -> pc_o=0x100.
- XLEN=16, pc_o=0xFFFC -> next 0x0000; async reset mid-run at pc_o=0x30 -> pc_o=0 immediately, pc_valid_o=0.
- PC_RAS_EN, RAS_DEPTH=4: 5 calls from 0x10,0x20,0x30,0x40,0x50 then 5 rets -> targets 0x54,0x44,0x34,0x24, then 5th ret ras_underflow_o=1, sequential increment.
